// File: rtl/dwt_lifting_ctrl_if.sv
// Stream bus of the lifting-DWT sequencer: sample input and coefficient-pair output.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. Once valid is raised the producer holds data/last/valid unchanged
// until that transfer. Ready may change freely and never depends on valid.
interface dwt_lifting_ctrl_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_d;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_a, out_d, out_valid, out_last
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_a, out_d, out_valid, out_last
  );
endinterface

// File: rtl/dwt_lifting_ctrl.sv
// Upstream sequencer for the single-precision lifting DWT stage.
// Fills a 3-sample window, replays it through a fixed 4-phase mux schedule
// (P0..P3, one cycle each, never stalled) and captures the resulting
// approximation/detail pair into a 1-deep output register.
module dwt_lifting_ctrl #(
  parameter int         DATA_W  = 32,   // IEEE-754 single; only 32 supported
  parameter logic [1:0] IDLE_S1 = 2'd3  // selects the idle constant
) (
  input  logic              clk,
  input  logic              rst_n,
  dwt_lifting_ctrl_if.slave bus,
  output logic [DATA_W-1:0] y2n,
  output logic [DATA_W-1:0] y2n_1,
  output logic [DATA_W-1:0] y2na,
  output logic [1:0]        s1,
  output logic              s2,
  output logic              s3,
  output logic              s4,
  output logic              s5,
  output logic              s6,
  input  logic [DATA_W-1:0] an_in,
  input  logic [DATA_W-1:0] dn_in,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    ST_FILL = 3'd0,
    ST_P0   = 3'd1,
    ST_P1   = 3'd2,
    ST_P2   = 3'd3,
    ST_P3   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        fill_q, fill_d;
  logic              last_seen_q, last_seen_d;
  logic [DATA_W-1:0] w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
  logic [DATA_W-1:0] y2n_q, y2n_d, y2n_1_q, y2n_1_d, y2na_q, y2na_d;
  logic [DATA_W-1:0] out_a_q, out_a_d, out_d_q, out_d_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;

  logic in_ready_w;
  logic in_accept;
  logic window_done;
  logic slot_free;
  logic rec_end;

  // Handshake qualifiers; in_ready is forced low while reset is held.
  always_comb begin
    in_ready_w  = rst_n && (state_q == ST_FILL) && (fill_q != 2'd3) && !last_seen_q;
    in_accept   = bus.in_valid && in_ready_w;
    window_done = (fill_q == 2'd3) || (last_seen_q && (fill_q != 2'd0));
    slot_free   = !out_valid_q || bus.out_ready;
    // A short window with last_seen means this pass is the record's final pair.
    rec_end     = last_seen_q && (fill_q != 2'd3);
  end

  // Next-state: window fill, phase sequencing, operand load, capture.
  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    last_seen_d = last_seen_q;
    w0_d        = w0_q;
    w1_d        = w1_q;
    w2_d        = w2_q;
    y2n_d       = y2n_q;
    y2n_1_d     = y2n_1_q;
    y2na_d      = y2na_q;
    out_a_d     = out_a_q;
    out_d_d     = out_d_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_FILL: begin
        if (in_accept) begin
          unique case (fill_q)
            2'd0:    w0_d = bus.in_data;
            2'd1:    w1_d = bus.in_data;
            default: w2_d = bus.in_data;
          endcase
          fill_d = fill_q + 2'd1;
          if (bus.in_last) begin
            last_seen_d = 1'b1;
          end
        end
        // Accept and start are mutually exclusive: accept needs fill<3 and
        // !last_seen, start needs fill==3 or last_seen.
        if (window_done && slot_free) begin
          state_d = ST_P0;
          y2n_d   = w0_q;
          // Symmetric extension at the record end mirrors around w0.
          y2n_1_d = (fill_q == 2'd1) ? w0_q : w1_q;
          y2na_d  = (fill_q == 2'd3) ? w2_q : w0_q;
        end
      end
      ST_P0: state_d = ST_P1;
      ST_P1: state_d = ST_P2;
      ST_P2: state_d = ST_P3;
      ST_P3: begin
        out_a_d     = an_in;
        out_d_d     = dn_in;
        out_valid_d = 1'b1;
        out_last_d  = rec_end;
        if (rec_end) begin
          fill_d      = 2'd0;
          last_seen_d = 1'b0;
        end else begin
          // Window slides by two samples: the old x[2n+2] becomes the new x[2n].
          w0_d   = w2_q;
          fill_d = 2'd1;
        end
        state_d = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      fill_q      <= 2'd0;
      last_seen_q <= 1'b0;
      w0_q        <= '0;
      w1_q        <= '0;
      w2_q        <= '0;
      y2n_q       <= '0;
      y2n_1_q     <= '0;
      y2na_q      <= '0;
      out_a_q     <= '0;
      out_d_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      last_seen_q <= last_seen_d;
      w0_q        <= w0_d;
      w1_q        <= w1_d;
      w2_q        <= w2_d;
      y2n_q       <= y2n_d;
      y2n_1_q     <= y2n_1_d;
      y2na_q      <= y2na_d;
      out_a_q     <= out_a_d;
      out_d_q     <= out_d_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Mux-select schedule decoded straight from the phase register.
  always_comb begin
    {s1, s2, s3, s4, s5, s6} = {IDLE_S1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    unique case (state_q)
      ST_P0:   {s1, s2, s3, s4, s5, s6} = {2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      ST_P1:   {s1, s2, s3, s4, s5, s6} = {2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      ST_P2:   {s1, s2, s3, s4, s5, s6} = {2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      ST_P3:   {s1, s2, s3, s4, s5, s6} = {2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      default: ;
    endcase
  end

  // Output drive.
  always_comb begin
    bus.in_ready  = in_ready_w;
    bus.out_a     = out_a_q;
    bus.out_d     = out_d_q;
    bus.out_valid = out_valid_q;
    bus.out_last  = out_last_q;
    y2n           = y2n_q;
    y2n_1         = y2n_1_q;
    y2na          = y2na_q;
    dbg_state     = state_q;
  end

endmodule
